// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares the single main-memory port between the instruction-fetch unit (IF)
// and the load/store data unit (DM). A granted request is latched, then
// sequenced through ISSUE -> WAIT -> DONE. Completion happens either on the
// memory ACK or when the bounded wait expires. A forced completion raises
// TIMEOUT together with the DONE pulse.
//
// Every output is a register, so each output is glitch-free and is cleared
// directly by the asynchronous reset.
//
// Ports
//   MEM_ARBITER_CLOCK_50            system clock (rising edge)
//   MEM_ARBITER_RESET_InLow         asynchronous active-low reset
//   MEM_ARBITER_IF_*                fetch request / address / data / done
//   MEM_ARBITER_DM_*                data request / we / address / data / done
//   MEM_ARBITER_MEM_*               memory address, write data, RD/WR, read
//                                   data, ACK
//   MEM_ARBITER_BUSY_Out            high whenever a transaction is in flight
//   MEM_ARBITER_TIMEOUT_Out         one-cycle pulse with DONE on forced
//                                   completion
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                     MEM_ARBITER_CLOCK_50,
  input  logic                     MEM_ARBITER_RESET_InLow,
  input  logic                     MEM_ARBITER_IF_REQ_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_IF_ADDRESS_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_IF_data_OutBUS,
  output logic                     MEM_ARBITER_IF_DONE_Out,
  input  logic                     MEM_ARBITER_DM_REQ_In,
  input  logic                     MEM_ARBITER_DM_WE_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_DM_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_DM_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_DM_data_OutBUS,
  output logic                     MEM_ARBITER_DM_DONE_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MEM_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MEM_data_OutBUS,
  output logic                     MEM_ARBITER_MEM_RD_Out,
  output logic                     MEM_ARBITER_MEM_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MEM_data_InBUS,
  input  logic                     MEM_ARBITER_MEM_ACK_In,
  output logic                     MEM_ARBITER_BUSY_Out,
  output logic                     MEM_ARBITER_TIMEOUT_Out
);

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic       last_grant_r;   // 0 = IF was granted last, 1 = DM
  logic       grant_dm_r;     // owner of the transaction in flight
  logic       we_r;           // transaction in flight is a write
  logic [3:0] wait_cnt_r;
  logic       grant_dm_s;
  logic       wait_exit_s;

  // Round-robin pick: on a tie, the port that was not served last wins.
  always_comb begin
    grant_dm_s = 1'b0;
    if (MEM_ARBITER_DM_REQ_In && MEM_ARBITER_IF_REQ_In) begin
      grant_dm_s = ~last_grant_r;
    end else if (MEM_ARBITER_DM_REQ_In) begin
      grant_dm_s = 1'b1;
    end else begin
      grant_dm_s = 1'b0;
    end
  end

  // WAIT ends on ACK or once the bounded wait has been used up.
  always_comb begin
    wait_exit_s = 1'b0;
    if (MEM_ARBITER_MEM_ACK_In || (wait_cnt_r == WAIT_LAST)) begin
      wait_exit_s = 1'b1;
    end else begin
      wait_exit_s = 1'b0;
    end
  end

  // Transaction sequencer: state, latched request and all registered outputs.
  always_ff @(posedge MEM_ARBITER_CLOCK_50 or negedge MEM_ARBITER_RESET_InLow) begin
    if (!MEM_ARBITER_RESET_InLow) begin
      state_r                        <= ST_IDLE;
      last_grant_r                   <= 1'b0;
      grant_dm_r                     <= 1'b0;
      we_r                           <= 1'b0;
      wait_cnt_r                     <= 4'd0;
      MEM_ARBITER_IF_data_OutBUS     <= {DATAWIDTH_BUS{1'b0}};
      MEM_ARBITER_DM_data_OutBUS     <= {DATAWIDTH_BUS{1'b0}};
      MEM_ARBITER_IF_DONE_Out        <= 1'b0;
      MEM_ARBITER_DM_DONE_Out        <= 1'b0;
      MEM_ARBITER_MEM_ADDRESS_OutBUS <= {DATAWIDTH_BUS{1'b0}};
      MEM_ARBITER_MEM_data_OutBUS    <= {DATAWIDTH_BUS{1'b0}};
      MEM_ARBITER_MEM_RD_Out         <= 1'b0;
      MEM_ARBITER_MEM_WR_Out         <= 1'b0;
      MEM_ARBITER_BUSY_Out           <= 1'b0;
      MEM_ARBITER_TIMEOUT_Out        <= 1'b0;
    end else begin
      // The completion flags are single-cycle pulses.
      MEM_ARBITER_IF_DONE_Out <= 1'b0;
      MEM_ARBITER_DM_DONE_Out <= 1'b0;
      MEM_ARBITER_TIMEOUT_Out <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (MEM_ARBITER_IF_REQ_In || MEM_ARBITER_DM_REQ_In) begin
            state_r              <= ST_ISSUE;
            grant_dm_r           <= grant_dm_s;
            last_grant_r         <= grant_dm_s;
            MEM_ARBITER_BUSY_Out <= 1'b1;
            // The memory-side registers act as the transaction latch.
            // Strobes rise here, so they are already high in ISSUE.
            if (grant_dm_s) begin
              we_r                           <= MEM_ARBITER_DM_WE_In;
              MEM_ARBITER_MEM_ADDRESS_OutBUS <= MEM_ARBITER_DM_ADDRESS_InBUS;
              MEM_ARBITER_MEM_RD_Out         <= ~MEM_ARBITER_DM_WE_In;
              MEM_ARBITER_MEM_WR_Out         <= MEM_ARBITER_DM_WE_In;
              if (MEM_ARBITER_DM_WE_In) begin
                MEM_ARBITER_MEM_data_OutBUS <= MEM_ARBITER_DM_data_InBUS;
              end else begin
                MEM_ARBITER_MEM_data_OutBUS <= {DATAWIDTH_BUS{1'b0}};
              end
            end else begin
              // Instruction fetches are always reads.
              we_r                           <= 1'b0;
              MEM_ARBITER_MEM_ADDRESS_OutBUS <= MEM_ARBITER_IF_ADDRESS_InBUS;
              MEM_ARBITER_MEM_data_OutBUS    <= {DATAWIDTH_BUS{1'b0}};
              MEM_ARBITER_MEM_RD_Out         <= 1'b1;
              MEM_ARBITER_MEM_WR_Out         <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          state_r    <= ST_WAIT;
          wait_cnt_r <= 4'd0;
        end

        ST_WAIT: begin
          if (wait_exit_s) begin
            state_r                 <= ST_DONE;
            MEM_ARBITER_MEM_RD_Out  <= 1'b0;
            MEM_ARBITER_MEM_WR_Out  <= 1'b0;
            MEM_ARBITER_TIMEOUT_Out <= ~MEM_ARBITER_MEM_ACK_In;
            if (grant_dm_r) begin
              MEM_ARBITER_DM_DONE_Out <= 1'b1;
            end else begin
              MEM_ARBITER_IF_DONE_Out <= 1'b1;
            end
            // Reads capture the bus at the completing edge, even on timeout.
            if (!we_r) begin
              if (grant_dm_r) begin
                MEM_ARBITER_DM_data_OutBUS <= MEM_ARBITER_MEM_data_InBUS;
              end else begin
                MEM_ARBITER_IF_data_OutBUS <= MEM_ARBITER_MEM_data_InBUS;
              end
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end

        ST_DONE: begin
          state_r              <= ST_IDLE;
          MEM_ARBITER_BUSY_Out <= 1'b0;
        end

        default: begin
          state_r                <= ST_IDLE;
          MEM_ARBITER_MEM_RD_Out <= 1'b0;
          MEM_ARBITER_MEM_WR_Out <= 1'b0;
          MEM_ARBITER_BUSY_Out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed bench for memory_arbiter (default TIMEOUT_CYCLES = 4). A table of
// single transactions is applied in a loop, followed by hand-written sequences
// for reset, request drop, ignored ACK and back-to-back round-robin. Inputs
// change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, ack;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_data, dm_data, mem_addr, mem_wdata, mem_rdata, mem_manual;
  logic        if_done, dm_done, rd, wr, busy, timeout;
  logic        use_model;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory model: the data depends on the address, unless a sequence drives it.
  assign mem_rdata = use_model ? (mem_addr ^ 32'h1080_0800) : mem_manual;

  memory_arbiter #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(4)) dut (
    .MEM_ARBITER_CLOCK_50           (clk),
    .MEM_ARBITER_RESET_InLow        (rst_n),
    .MEM_ARBITER_IF_REQ_In          (if_req),
    .MEM_ARBITER_IF_ADDRESS_InBUS   (if_addr),
    .MEM_ARBITER_IF_data_OutBUS     (if_data),
    .MEM_ARBITER_IF_DONE_Out        (if_done),
    .MEM_ARBITER_DM_REQ_In          (dm_req),
    .MEM_ARBITER_DM_WE_In           (dm_we),
    .MEM_ARBITER_DM_ADDRESS_InBUS   (dm_addr),
    .MEM_ARBITER_DM_data_InBUS      (dm_wdata),
    .MEM_ARBITER_DM_data_OutBUS     (dm_data),
    .MEM_ARBITER_DM_DONE_Out        (dm_done),
    .MEM_ARBITER_MEM_ADDRESS_OutBUS (mem_addr),
    .MEM_ARBITER_MEM_data_OutBUS    (mem_wdata),
    .MEM_ARBITER_MEM_RD_Out         (rd),
    .MEM_ARBITER_MEM_WR_Out         (wr),
    .MEM_ARBITER_MEM_data_InBUS     (mem_rdata),
    .MEM_ARBITER_MEM_ACK_In         (ack),
    .MEM_ARBITER_BUSY_Out           (busy),
    .MEM_ARBITER_TIMEOUT_Out        (timeout)
  );

  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic        ack;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        exp_dm;       // 1 = DM expected to be granted
    logic        exp_to;
    int          exp_lat;      // cycles from request cycle N to DONE
    int          exp_rd;       // cycles with RD high
    int          exp_wr;       // cycles with WR high
    logic [31:0] exp_if_data;
    logic [31:0] exp_dm_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_if_data"}, if_data, 32'h0);
    check({name, "_dm_data"}, dm_data, 32'h0);
    check({name, "_mem_addr"}, mem_addr, 32'h0);
    check({name, "_mem_wdata"}, mem_wdata, 32'h0);
    check({name, "_flags"}, {26'h0, if_done, dm_done, rd, wr, busy, timeout}, 32'h0);
  endtask

  initial begin
    int          lat, rd_n, wr_n, busy_n, n_if, n_dm, n_done;
    logic        saw_if, saw_dm, to_at, both;
    logic [31:0] addr1, data1;
    int          done_cyc[4];
    logic        done_dm[4];

    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; ack = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    use_model = 1'b1; mem_manual = 32'h0;

    //          ifr   dmr   we    ack   if_addr       dm_addr       wdata
    //          dm    to    lat rd wr  exp_if        exp_dm
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                1'b0, 1'b0, 3, 2, 0, 32'h1080_0800, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0804, 32'hDEAD_BEEF,
                1'b1, 1'b1, 6, 0, 5, 32'h1080_0800, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000,
                1'b1, 1'b0, 3, 2, 0, 32'h1080_0800, 32'h1080_0900};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0040, 32'h0000_0000,
                1'b0, 1'b0, 3, 2, 0, 32'h1080_0820, 32'h1080_0900};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0024, 32'h0000_0044, 32'h0000_0000,
                1'b1, 1'b0, 3, 2, 0, 32'h1080_0820, 32'h1080_0844};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0000,
                1'b0, 1'b1, 6, 5, 0, 32'h1080_0830, 32'h1080_0844};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0808, 32'h1234_5678,
                1'b1, 1'b0, 3, 0, 2, 32'h1080_0830, 32'h1080_0844};

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // ---------------- table-driven single transactions ----------------
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if_req = vecs[i].if_req; dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      ack = vecs[i].ack; if_addr = vecs[i].if_addr; dm_addr = vecs[i].dm_addr;
      dm_wdata = vecs[i].dm_wdata;
      lat = 0; rd_n = 0; wr_n = 0; busy_n = 0; both = 1'b0;
      saw_if = 1'b0; saw_dm = 1'b0; to_at = 1'b0; addr1 = 32'h0; data1 = 32'h0;
      for (int k = 1; k <= 30 && lat == 0; k++) begin
        @(negedge clk);
        if (rd) rd_n++;
        if (wr) wr_n++;
        if (busy) busy_n++;
        if (rd && wr) both = 1'b1;
        if (k == 1) begin addr1 = mem_addr; data1 = mem_wdata; end
        if (if_done || dm_done) begin
          lat = k; saw_if = if_done; saw_dm = dm_done; to_at = timeout;
          if_req = 1'b0; dm_req = 1'b0;
        end
      end
      if_req = 1'b0; dm_req = 1'b0; ack = 1'b0;
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_grantee", i), {30'h0, saw_if, saw_dm},
            vecs[i].exp_dm ? 32'h1 : 32'h2);
      check($sformatf("v%0d_timeout", i), {31'h0, to_at}, {31'h0, vecs[i].exp_to});
      check($sformatf("v%0d_rd_cycles", i), rd_n, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_cycles", i), wr_n, vecs[i].exp_wr);
      check($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].exp_lat);
      check($sformatf("v%0d_rd_wr_overlap", i), {31'h0, both}, 32'h0);
      check($sformatf("v%0d_mem_addr", i), addr1,
            vecs[i].exp_dm ? vecs[i].dm_addr : vecs[i].if_addr);
      if (vecs[i].exp_dm && vecs[i].dm_we)
        check($sformatf("v%0d_mem_wdata", i), data1, vecs[i].dm_wdata);
      @(negedge clk);
      check($sformatf("v%0d_idle_flags", i), {28'h0, if_done, dm_done, busy, timeout}, 32'h0);
      check($sformatf("v%0d_if_data", i), if_data, vecs[i].exp_if_data);
      check($sformatf("v%0d_dm_data", i), dm_data, vecs[i].exp_dm_data);
    end

    // ---------------- reset in the middle of a DM read WAIT ----------------
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0700; ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_wait_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_dm = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dm_done) n_dm++;
    end
    check("rst_no_dm_done", n_dm, 0);
    check("rst_busy_after", {31'h0, busy}, 32'h0);

    // ---------------- DM request dropped after the grant ----------------
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0500; ack = 1'b1;
    n_dm = 0; n_if = 0; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) dm_req = 1'b0;
      if (dm_done) begin n_dm++; if (lat == 0) lat = k; end
      if (if_done) n_if++;
    end
    ack = 1'b0;
    check("drop_dm_done_count", n_dm, 1);
    check("drop_dm_done_cycle", lat, 3);
    check("drop_if_done_count", n_if, 0);
    check("drop_busy_after", {31'h0, busy}, 32'h0);
    check("drop_dm_data", dm_data, 32'h1080_0D00);

    // ---------------- ACK outside WAIT is ignored ----------------
    @(negedge clk);
    ack = 1'b1;
    repeat (2) @(negedge clk);
    ack = 1'b0; use_model = 1'b0; mem_manual = 32'hA000_0000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0600;
    lat = 0; to_at = 1'b0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (dm_done) begin lat = k; to_at = timeout; dm_req = 1'b0; end
      ack = (k == 1);                      // ACK pulse during ISSUE only
      mem_manual = 32'hA000_0000 + 32'(k); // distinct bus value per cycle
    end
    dm_req = 1'b0; ack = 1'b0;
    @(negedge clk);
    use_model = 1'b1;
    check("early_ack_latency", lat, 6);
    check("early_ack_timeout", {31'h0, to_at}, 32'h1);
    check("early_ack_dm_data", dm_data, 32'hA000_0005);

    // ---------------- both requests held from reset ----------------
    rst_n = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; ack = 1'b1;
    if_addr = 32'h0000_0200; dm_addr = 32'h0000_0300;
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0; both = 1'b0;
    for (int j = 0; j < 4; j++) begin done_cyc[j] = 0; done_dm[j] = 1'b0; end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (rd && wr) both = 1'b1;
      if (if_done || dm_done) begin
        if (n_done < 4) begin done_cyc[n_done] = k; done_dm[n_done] = dm_done; end
        n_done++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0; ack = 1'b0;
    check("rr_done_count", n_done, 4);
    check("rr_overlap", {31'h0, both}, 32'h0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rr_grant%0d", j), {31'h0, done_dm[j]}, (j % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("rr_cycle%0d", j), done_cyc[j], 3 + 4 * j);
    end
    repeat (6) @(negedge clk);
    check("rr_if_data", if_data, 32'h1080_0A00);
    check("rr_dm_data", dm_data, 32'h1080_0B00);
    check("rr_busy_end", {31'h0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and bus sequencer in front of the 32-bit main memory. It shares the single memory port between the CPU instruction-fetch unit (IF) and the load/store data unit (DM), and drives the memory's RD/WR strobes and address/data buses. It completes each transaction on the memory ACK or on a bounded wait. It sits between the CPU datapath and the main memory, and is the only block that drives the memory control inputs.

## Interface
Parameters:
- DATAWIDTH_BUS, 32, width of address and data buses
- TIMEOUT_CYCLES, 4, maximum WAIT cycles before forced completion (legal range 1..15)

Ports:
- MEM_ARBITER_CLOCK_50  in  1  system clock; all state changes on the rising edge
- MEM_ARBITER_RESET_InLow  in  1  asynchronous, active-low reset
- MEM_ARBITER_IF_REQ_In  in  1  fetch request; held high until IF_DONE
- MEM_ARBITER_IF_ADDRESS_InBUS  in  DATAWIDTH_BUS  fetch address
- MEM_ARBITER_IF_data_OutBUS  out  DATAWIDTH_BUS  last fetched word
- MEM_ARBITER_IF_DONE_Out  out  1  one-cycle completion pulse to IF
- MEM_ARBITER_DM_REQ_In  in  1  data request; held high until DM_DONE
- MEM_ARBITER_DM_WE_In  in  1  1 = write, 0 = read
- MEM_ARBITER_DM_ADDRESS_InBUS  in  DATAWIDTH_BUS  data address
- MEM_ARBITER_DM_data_InBUS  in  DATAWIDTH_BUS  store data
- MEM_ARBITER_DM_data_OutBUS  out  DATAWIDTH_BUS  last loaded word
- MEM_ARBITER_DM_DONE_Out  out  1  one-cycle completion pulse to DM
- MEM_ARBITER_MEM_ADDRESS_OutBUS  out  DATAWIDTH_BUS  address to memory
- MEM_ARBITER_MEM_data_OutBUS  out  DATAWIDTH_BUS  write data to memory
- MEM_ARBITER_MEM_RD_Out  out  1  memory read strobe
- MEM_ARBITER_MEM_WR_Out  out  1  memory write strobe
- MEM_ARBITER_MEM_data_InBUS  in  DATAWIDTH_BUS  read data from memory
- MEM_ARBITER_MEM_ACK_In  in  1  memory acknowledge
- MEM_ARBITER_BUSY_Out  out  1  high whenever the state is not IDLE
- MEM_ARBITER_TIMEOUT_Out  out  1  one-cycle pulse, coincident with DONE, when completion was forced

## Operation
- FSM states and transitions:
  - IDLE: if any REQ is high, grant and latch the granted port's address, WE and store data into internal registers, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive the latched address and data, and assert RD (read) or WR (write). Always go to WAIT after one cycle.
  - WAIT: keep the strobe asserted and increment the 4-bit wait counter, which is cleared on entry. On ACK=1, or when counter == TIMEOUT_CYCLES-1, go to DONE. On a read, capture MEM_data_InBUS into the grantee's read register at this edge.
  - DONE: deassert RD/WR, pulse the grantee's DONE, pulse TIMEOUT if ACK was not seen, then go to IDLE.
- Arbitration is round-robin on a 1-bit last_grant register:
  - When both ports request, the port not granted last wins.
  - When only one port requests, it wins.
  - last_grant updates when leaving IDLE.
- RD and WR are never high simultaneously. Both are low in IDLE and DONE.
- The memory address, memory data and strobe outputs are registered outputs of the latched transaction. Requester inputs are not used after the grant.
- Read registers hold their value until the next completed read on the same port. Writes leave both read registers unchanged.
- A requester that deasserts REQ mid-transaction is ignored: the transaction completes and DONE still pulses.
- A REQ still high in the IDLE cycle after DONE starts a new transaction (back-to-back).
- Reset, asynchronous at any time including mid-transaction:
  - State goes to IDLE, last_grant goes to IF, and the counter is cleared.
  - All outputs go to 0: both read registers, both DONE pulses, BUSY, TIMEOUT, RD, WR, memory address and memory data.
  - No DONE is issued for the aborted transaction.

## Timing
- With REQ high in IDLE at cycle N: ISSUE at N+1 and WAIT from N+2.
- With ACK high in the first WAIT cycle: DONE at N+3, and read data is valid on the data_OutBUS from N+3 onward.
- With no ACK: WAIT lasts TIMEOUT_CYCLES cycles and DONE occurs at N+2+TIMEOUT_CYCLES, together with TIMEOUT.
- A back-to-back transaction occupies a minimum of 4 cycles.
- BUSY is high from N+1 through DONE inclusive.
- ACK is sampled only in WAIT. An ACK during IDLE, ISSUE or DONE is ignored.

## Test plan
- Reset mid-WAIT: assert RESET_InLow=0 during a DM read -> all outputs are 0 immediately, BUSY=0, and no DM_DONE ever follows.
- IF read, ACK tied 1, memory returns 0x10800800 for address 0x000 -> RD high at N+1..N+2, IF_DONE at N+3, IF_data_OutBUS=0x10800800, TIMEOUT=0.
- DM write to 0x804 with data 0xDEADBEEF, ACK held 0 -> WR high for 1+TIMEOUT_CYCLES cycles, DM_DONE and TIMEOUT at N+6 (default TIMEOUT_CYCLES=4), and DM_data_OutBUS unchanged.
- Both REQ held high continuously from reset -> grants alternate DM, IF, DM, IF, with DONE pulses exactly 4 cycles apart when ACK=1.
- DM REQ dropped one cycle after the grant -> the transaction completes and DM_DONE still pulses once. No second transaction starts.
- ACK pulsed during IDLE only, then a DM read with ACK=0 -> the early ACK is ignored and completion occurs via timeout, with TIMEOUT=1 and DM_data_OutBUS equal to the memory data at the last WAIT cycle.
